mdu_sequencer: RTL and testbench

- Sequences the M-extension execute unit: accepts an M-type op from the execute stage and starts the iterative multiplier or the iterative divider.
- Holds the pipeline with a stall while the unit is busy, then returns one registered result with a one-cycle valid strobe.
- Sits between the execute-stage decode/operand muxes and the mul/div datapaths. Replaces ad-hoc done/flag glue with an explicit FSM.

---
 rtl/mdu_sequencer.sv | 218 +++++++++++++++++++++
 tb/tb_mdu_sequencer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_sequencer.sv
// mdu_sequencer
//   Sequences the M-extension execute unit. An M-type op presented by the
//   execute stage is latched and handed to either the iterative multiplier or
//   the iterative divider. The pipeline is stalled while the unit works. The
//   unit's result is then returned as one registered value with a one-cycle
//   valid strobe.
//
// Optional feature (compile-time macro MDU_DIVZERO_BYPASS_EN):
//   - A divide or remainder by zero bypasses the divider. The architectural
//     result is produced one cycle after acceptance.
//   - A busy watchdog forces completion with a result of 0 after
//     TIMEOUT_CYCLES busy cycles.
//
// Parameters
//   TIMEOUT_CYCLES  busy cycles before a forced abort (watchdog build only)
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   valid_e, alu_op_e        execute-stage valid and operation code
//   src_a_e, src_b_e         rs1 / rs2 operands
//   flush                    kill the in-flight execute instruction
//   stall_o                  hold fetch/decode/execute
//   result_o, result_valid_o registered M-op result and its one-cycle strobe
//   mul_start, mul_opcode    multiplier start pulse and op select
//   div_start, div_opcode    divider start pulse and op select
//   op_a, op_b               latched operands shared by both units
//   mul_done, mul_result     multiplier completion strobe and result
//   div_done, div_result     divider completion strobe and result
module mdu_sequencer #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_e,
    input  logic [4:0]  alu_op_e,
    input  logic [31:0] src_a_e,
    input  logic [31:0] src_b_e,
    input  logic        flush,
    output logic        stall_o,
    output logic [31:0] result_o,
    output logic        result_valid_o,
    output logic        mul_start,
    output logic [1:0]  mul_opcode,
    output logic        div_start,
    output logic [1:0]  div_opcode,
    output logic [31:0] op_a,
    output logic [31:0] op_b,
    input  logic        mul_done,
    input  logic [31:0] mul_result,
    input  logic        div_done,
    input  logic [31:0] div_result
);

    localparam logic [4:0] OP_MUL    = 5'b01011;
    localparam logic [4:0] OP_MULH   = 5'b01100;
    localparam logic [4:0] OP_MULHSU = 5'b01101;
    localparam logic [4:0] OP_MULHU  = 5'b01110;
    localparam logic [4:0] OP_DIV    = 5'b01111;
    localparam logic [4:0] OP_DIVU   = 5'b10000;
    localparam logic [4:0] OP_REM    = 5'b10001;
    localparam logic [4:0] OP_REMU   = 5'b10010;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        MUL_BUSY = 3'd1,
        DIV_BUSY = 3'd2,
        DONE     = 3'd3,
        DRAIN    = 3'd4
    } state_t;

    state_t      state;
    logic        busy_div;      // which unit owns the current/draining op
    logic        is_mul_op;
    logic        is_div_op;
    logic        is_m_op;
    logic        accept;
    logic [1:0]  op_sel;
    logic        unit_done;
    logic [31:0] unit_result;
    logic        div_zero;
    logic [31:0] zero_result;
    logic        timeout;

    assign is_mul_op = (alu_op_e >= OP_MUL) && (alu_op_e <= OP_MULHU);
    assign is_div_op = (alu_op_e >= OP_DIV) && (alu_op_e <= OP_REMU);
    assign is_m_op   = is_mul_op || is_div_op;
    assign accept    = (state == IDLE) && valid_e && is_m_op && !flush;

    // Both units order their sub-ops the same way, so one decode feeds both.
    always_comb begin
        op_sel = 2'b00;
        case (alu_op_e)
            OP_MUL,    OP_DIV:  op_sel = 2'b00;
            OP_MULH,   OP_DIVU: op_sel = 2'b01;
            OP_MULHSU, OP_REM:  op_sel = 2'b10;
            OP_MULHU,  OP_REMU: op_sel = 2'b11;
            default:            op_sel = 2'b00;
        endcase
    end

    // Only the unit that was started may complete the op; a stray strobe
    // from the other unit is ignored.
    assign unit_done   = busy_div ? div_done   : mul_done;
    assign unit_result = busy_div ? div_result : mul_result;

    // Stall is combinational so the acceptance cycle already holds the
    // pipeline. In DRAIN, only a new M op waiting behind the flushed one stalls.
    assign stall_o = !rst && (accept ||
                              (state == MUL_BUSY) || (state == DIV_BUSY) ||
                              ((state == DRAIN) && valid_e && is_m_op));

`ifdef MDU_DIVZERO_BYPASS_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wd_cnt;

    assign div_zero    = is_div_op && (src_b_e == 32'd0);
    // Architectural divide-by-zero results: quotient all ones, remainder = rs1.
    assign zero_result = ((alu_op_e == OP_DIV) || (alu_op_e == OP_DIVU)) ? 32'hFFFF_FFFF : src_a_e;

    // Counts busy (and drain) cycles. It reads 0 in the first busy cycle, so
    // it reaches TIMEOUT_CYCLES-1 in the TIMEOUT_CYCLES-th busy cycle.
    always_ff @(posedge clk) begin
        if (rst || (state == IDLE) || (state == DONE)) begin
            wd_cnt <= '0;
        end else begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end

    assign timeout = (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
`else
    assign div_zero    = 1'b0;
    assign zero_result = 32'd0;
    // No watchdog in this build. The expression is constant 0 for any usable
    // TIMEOUT_CYCLES.
    assign timeout     = (TIMEOUT_CYCLES == 0);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            busy_div       <= 1'b0;
            result_o       <= 32'd0;
            result_valid_o <= 1'b0;
            mul_start      <= 1'b0;
            div_start      <= 1'b0;
            mul_opcode     <= 2'b00;
            div_opcode     <= 2'b00;
            op_a           <= 32'd0;
            op_b           <= 32'd0;
        end else begin
            // Start and valid are single-cycle pulses by default.
            mul_start      <= 1'b0;
            div_start      <= 1'b0;
            result_valid_o <= 1'b0;

            case (state)
                IDLE: begin
                    if (accept) begin
                        op_a     <= src_a_e;
                        op_b     <= src_b_e;
                        busy_div <= is_div_op;
                        if (is_div_op) begin
                            div_opcode <= op_sel;
                        end else begin
                            mul_opcode <= op_sel;
                        end

                        if (div_zero) begin
                            result_o       <= zero_result;
                            result_valid_o <= 1'b1;
                            state          <= DONE;
                        end else if (is_div_op) begin
                            div_start <= 1'b1;
                            state     <= DIV_BUSY;
                        end else begin
                            mul_start <= 1'b1;
                            state     <= MUL_BUSY;
                        end
                    end
                end

                MUL_BUSY, DIV_BUSY: begin
                    if (unit_done) begin
                        // A flush coinciding with completion kills the result.
                        if (flush) begin
                            state <= IDLE;
                        end else begin
                            result_o       <= unit_result;
                            result_valid_o <= 1'b1;
                            state          <= DONE;
                        end
                    end else if (flush) begin
                        // The unit cannot be aborted; wait for it in DRAIN.
                        state <= DRAIN;
                    end else if (timeout) begin
                        result_o       <= 32'd0;
                        result_valid_o <= 1'b1;
                        state          <= DONE;
                    end
                end

                DRAIN: begin
                    if (unit_done || timeout) begin
                        state <= IDLE;
                    end
                end

                // The held instruction is not re-sampled here, so it is not reissued.
                DONE: state <= IDLE;

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Testbench for mdu_sequencer. The bench acts as both the execute stage and
// the multiplier/divider units. It drives directed ops with hand-computed
// results. From each op's accept cycle and done latency, it schedules the
// expected per-cycle values of stall, start, valid and result. One compare
// process checks these values every cycle.
module tb_mdu_sequencer;

    localparam int TO = 64;
    localparam int N  = 2048;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_e;
    logic [4:0]  alu_op_e;
    logic [31:0] src_a_e, src_b_e;
    logic        flush;
    logic        stall_o;
    logic [31:0] result_o;
    logic        result_valid_o;
    logic        mul_start, div_start;
    logic [1:0]  mul_opcode, div_opcode;
    logic [31:0] op_a, op_b;
    logic        mul_done, div_done;
    logic [31:0] mul_result, div_result;

    mdu_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .valid_e(valid_e), .alu_op_e(alu_op_e),
        .src_a_e(src_a_e), .src_b_e(src_b_e), .flush(flush),
        .stall_o(stall_o), .result_o(result_o), .result_valid_o(result_valid_o),
        .mul_start(mul_start), .mul_opcode(mul_opcode),
        .div_start(div_start), .div_opcode(div_opcode),
        .op_a(op_a), .op_b(op_b),
        .mul_done(mul_done), .mul_result(mul_result),
        .div_done(div_done), .div_result(div_result)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;
    bit run      = 1'b0;

    // Per-cycle expectations (default: everything low, nothing to check).
    bit          exp_stall [N];
    bit          exp_valid [N];
    bit          exp_mstart[N];
    bit          exp_dstart[N];
    bit          chk_ops   [N];
    bit          exp_isdiv [N];
    logic [31:0] exp_res   [N];
    logic [31:0] exp_a     [N];
    logic [31:0] exp_b     [N];
    logic [1:0]  exp_opc   [N];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, req);
        end
    endtask

    // RISC-V M-extension reference arithmetic.
    function automatic logic [31:0] model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] sa, sb, ua, ub, p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            5'd11: begin p = ua * ub; return p[31:0];  end
            5'd12: begin p = sa * sb; return p[63:32]; end
            5'd13: begin p = sa * ub; return p[63:32]; end
            5'd14: begin p = ua * ub; return p[63:32]; end
            5'd15: return (b == 0) ? 32'hFFFF_FFFF :
                          (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h8000_0000 :
                          32'($signed(a) / $signed(b));
            5'd16: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            5'd17: return (b == 0) ? a :
                          (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'd0 :
                          32'($signed(a) % $signed(b));
            5'd18: return (b == 0) ? a : a % b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [1:0] opc(input logic [4:0] op);
        logic [4:0] d;
        d = (op >= 5'd15) ? op - 5'd15 : op - 5'd11;
        return d[1:0];
    endfunction

    // Single compare process: every cycle once out of reset.
    always @(negedge clk) begin
        if (run && cyc < N) begin
            check("stall",        {31'd0, stall_o},        {31'd0, exp_stall[cyc]});
            check("result_valid", {31'd0, result_valid_o}, {31'd0, exp_valid[cyc]});
            check("mul_start",    {31'd0, mul_start},      {31'd0, exp_mstart[cyc]});
            check("div_start",    {31'd0, div_start},      {31'd0, exp_dstart[cyc]});
            if (exp_valid[cyc]) check("result", result_o, exp_res[cyc]);
            if (chk_ops[cyc]) begin
                check("op_a", op_a, exp_a[cyc]);
                check("op_b", op_b, exp_b[cyc]);
                if (exp_isdiv[cyc]) check("div_opcode", {30'd0, div_opcode}, {30'd0, exp_opc[cyc]});
                else                check("mul_opcode", {30'd0, mul_opcode}, {30'd0, exp_opc[cyc]});
            end
        end
    end

    // Issue one M op and play the unit.
    //   k  : done arrives k cycles after acceptance (0 = never, watchdog).
    //   fl : >0 flush fl cycles after acceptance, -1 flush in the DONE cycle,
    //        0 no flush.
    //   lit: hand-computed result checked in the DONE cycle.
    // The pipeline keeps valid_e high on the same op until it advances.
    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int k, input int fl, input logic [31:0] lit);
        int T, term, lastc;
        bit isdiv, byp;
        @(posedge clk); #1;
        T     = cyc;
        isdiv = (op >= 5'd15);
        byp   = 1'b0;
`ifdef MDU_DIVZERO_BYPASS_EN
        byp   = isdiv && (b == 32'd0);
`endif
        valid_e = 1'b1; alu_op_e = op; src_a_e = a; src_b_e = b;
        term  = (k > 0) ? k : TO;
        exp_stall[T] = 1'b1;
        if (byp) begin
            exp_valid[T+1] = 1'b1;
            exp_res[T+1]   = model(op, a, b);
            lastc = 1;
        end else begin
            if (isdiv) exp_dstart[T+1] = 1'b1;
            else       exp_mstart[T+1] = 1'b1;
            for (int i = 1; i <= term; i++) begin
                chk_ops[T+i] = 1'b1; exp_a[T+i] = a; exp_b[T+i] = b;
                exp_opc[T+i] = opc(op); exp_isdiv[T+i] = isdiv;
            end
            if (fl > 0) begin
                for (int i = 1; i <= fl; i++) exp_stall[T+i] = 1'b1;
                // A new M op waits behind the drain in its last two cycles.
                exp_stall[T+k-1] = 1'b1;
                exp_stall[T+k]   = 1'b1;
                lastc = k;
            end else begin
                for (int i = 1; i <= term; i++) exp_stall[T+i] = 1'b1;
                exp_valid[T+term+1] = 1'b1;
                exp_res[T+term+1]   = (k > 0) ? model(op, a, b) : 32'd0;
                lastc = term + 1;
            end
        end
        for (int c = 1; c <= lastc; c++) begin
            @(posedge clk); #1;
            mul_done = 1'b0; div_done = 1'b0; flush = 1'b0;
            if (!byp && k > 0 && c == k) begin
                // The unit works from the latched operands it was handed.
                if (isdiv) begin div_done = 1'b1; div_result = model(op, op_a, op_b); end
                else       begin mul_done = 1'b1; mul_result = model(op, op_a, op_b); end
            end
            if (!byp && isdiv && c == 2) begin mul_done = 1'b1; mul_result = 32'hDEAD_BEEF; end
            if (fl > 0) begin
                if (c == fl) flush = 1'b1;
                if (c > fl) begin valid_e = 1'b1; alu_op_e = (c >= k - 1) ? 5'd11 : 5'd0; end
            end
            if (fl < 0 && c == lastc) flush = 1'b1;
            if (c == lastc && fl <= 0) begin
                @(negedge clk);
                check("lit_result", result_o, lit);
            end
        end
        @(posedge clk); #1;
        valid_e = 1'b0; flush = 1'b0; mul_done = 1'b0; div_done = 1'b0; alu_op_e = 5'd0;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout at cycle %0d", cyc);
        $fatal(1, "simulation time limit");
    end

    initial begin
        int T;
        rst = 1'b1; valid_e = 1'b0; alu_op_e = 5'd0; src_a_e = 32'd0; src_b_e = 32'd0;
        flush = 1'b0; mul_done = 1'b0; div_done = 1'b0; mul_result = 32'd0; div_result = 32'd0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0; run = 1'b1;
        @(negedge clk);
        check("rst_result",  result_o, 32'd0);
        check("rst_op_a",    op_a, 32'd0);
        check("rst_op_b",    op_b, 32'd0);
        check("rst_opcodes", {28'd0, mul_opcode, div_opcode}, 32'd0);

        issue(5'd11, 32'd7,          32'd6,          32, 0, 32'h0000_002A); // MUL
        issue(5'd14, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5,  0, 32'hFFFF_FFFE); // MULHU
        issue(5'd15, 32'hFFFF_FFEC,  32'd3,          10, 0, 32'hFFFF_FFFA); // DIV -20/3
        issue(5'd17, 32'hFFFF_FFEC,  32'd3,          8,  0, 32'hFFFF_FFFE); // REM -20%3
        issue(5'd12, 32'h8000_0000,  32'd2,          1,  0, 32'hFFFF_FFFF); // MULH, done with start
        issue(5'd13, 32'hFFFF_FFFF,  32'd2,          2,  0, 32'hFFFF_FFFF); // MULHSU
        issue(5'd16, 32'd100,        32'd7,          1,  0, 32'd14);        // DIVU
        issue(5'd18, 32'd100,        32'd7,          3, -1, 32'd2);         // REMU, flush in DONE
        issue(5'd11, 32'd7,          32'd6,          32, 5, 32'd0);         // flush -> DRAIN
        issue(5'd16, 32'd100,        32'd0,          4,  0, 32'hFFFF_FFFF); // DIVU by zero
        issue(5'd17, 32'd123,        32'd0,          2,  0, 32'd123);       // REM by zero
        issue(5'd15, 32'h8000_0000,  32'hFFFF_FFFF,  3,  0, 32'h8000_0000); // DIV overflow

        // Non-M ops, a flushed M op, and an invalid M op are all ignored.
        @(posedge clk); #1 valid_e = 1'b1; alu_op_e = 5'd0;
        @(posedge clk); #1 alu_op_e = 5'd19;
        @(posedge clk); #1 alu_op_e = 5'd11; flush = 1'b1;
        @(posedge clk); #1 valid_e = 1'b0; flush = 1'b0; alu_op_e = 5'd15;
        @(posedge clk); #1 alu_op_e = 5'd0;

        // Reset in the middle of a divide; a late done must be ignored.
        @(posedge clk); #1;
        T = cyc;
        valid_e = 1'b1; alu_op_e = 5'd15; src_a_e = 32'hFFFF_FFEC; src_b_e = 32'd3;
        for (int i = 0; i <= 4; i++) exp_stall[T+i] = 1'b1;
        exp_dstart[T+1] = 1'b1;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1; valid_e = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_result",  result_o, 32'd0);
        check("midrst_op_a",    op_a, 32'd0);
        check("midrst_op_b",    op_b, 32'd0);
        check("midrst_opcodes", {28'd0, mul_opcode, div_opcode}, 32'd0);
        repeat (2) @(posedge clk);
        #1 div_done = 1'b1; div_result = 32'h1234_5678;
        @(posedge clk); #1 div_done = 1'b0;

`ifdef MDU_DIVZERO_BYPASS_EN
        issue(5'd11, 32'd3, 32'd4, 0, 0, 32'd0); // watchdog: unit never finishes
`endif

        repeat (3) @(posedge clk);
        #1 run = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
